ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the St.PU five-stage MIPS-subset pipeline. It sits directly downstream of the ID stage and consumes its aluop/alusel/reg1/reg2/wd/wreg outputs after the ID/EX latch.
- Computes logic, shift and arithmetic results in the same cycle. The write-back triple (wd_o, wreg_o, wdata_o) also feeds back to ID as ex_wd_i/ex_wreg_i/ex_wdata_i for forwarding.
- Adds a 32-iteration radix-2 divider for DIV/DIVU with a pipeline stall request and a HI/LO write port.

Parameters:
- DATA_W, 32, operand/result width (RegBus)
- ADDR_W, 5, register address width (RegAddrBus)
- ALUOP_W, 8, ALU operation code width (AluOpBus)
- ALUSEL_W, 3, result-type select width (AluSelBus)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset
- aluop_i  in  ALUOP_W  operation code from ID/EX
- alusel_i  in  ALUSEL_W  result-type select
- reg1_i  in  DATA_W  operand 1; shift amount in [4:0] for shifts
- reg2_i  in  DATA_W  operand 2; shifted value for shifts
- wd_i  in  ADDR_W  destination register
- wreg_i  in  1  write enable
- annul_i  in  1  flush: abort any in-flight divide
- wd_o  out  ADDR_W  destination register (= wd_i)
- wreg_o  out  1  final write enable
- wdata_o  out  DATA_W  result
- whilo_o  out  1  HI/LO write strobe, one cycle
- hi_o  out  DATA_W  remainder
- lo_o  out  DATA_W  quotient
- stallreq_o  out  1  freeze IF/ID/EX while a divide is running

Behaviour:
- Reset is rst: synchronous, active-high. While rst=1, every output is 0 and the FSM returns to IDLE at the next edge.
- Combinational path, 0 latency. wdata_o is selected by alusel_i:
  - LOGIC(001): AND, OR, XOR, NOR.
  - SHIFT(010): SLL, SRL, SRA of reg2_i by reg1_i[4:0]. SRA replicates reg2_i[31].
  - ARITHMETIC(100): ADD/ADDU/SUB/SUBU are mod 2^32. SLT is a signed compare, SLTU unsigned; result is 32'h1 or 32'h0.
  - NOP(000) or any unknown select: wdata_o=0.
- Overflow: ADD_OP or SUB_OP signed overflow forces wreg_o=0. Detection: operands of the effective sum share a sign and the result sign differs. Otherwise wreg_o=wreg_i.
- Divider FSM states: IDLE, DZERO, ON, END.
  - IDLE: when aluop_i is DIV or DIVU and annul_i=0, stallreq_o=1 combinationally. If reg2_i=0 go to DZERO; else latch |dividend|, |divisor| (DIV) or raw values (DIVU), clear cnt, go to ON.
  - DZERO: stallreq_o=1; result={0,0}; go to END.
  - ON: stallreq_o=1. Each cycle does one shift-subtract step on a 65-bit partial remainder and increments cnt. After the 32nd step go to END.
  - END: stallreq_o=0, whilo_o=1, hi_o=remainder, lo_o=quotient. Return to IDLE unconditionally at the next edge, so the held DIV cannot restart.
  - In every other state whilo_o, hi_o and lo_o are 0.
- Signed fixup (DIV): negate the quotient when operand signs differ; the remainder takes the dividend's sign.
- Latency, counting the cycle the DIV is first presented as cycle 0:
  - Normal divide: END in cycle 33; stallreq_o is high in cycles 0..32.
  - Divide by zero: END in cycle 2.
- Upstream holds inputs stable while stallreq_o=1.
- annul_i=1 in any state: next state IDLE, stallreq_o=0 that cycle, no whilo_o pulse. The partial result is discarded.
- DIV/DIVU never write the GPR file: wreg_o follows wreg_i, which ID drives to 0 for these ops.

Decomposition:
- Shared package holds:
  - widths: RegBus, RegAddrBus, AluOpBus, AluSelBus;
  - aluop codes: AND 8'h24, OR 8'h25, XOR 8'h26, NOR 8'h27, SLL 8'h7C, SRL 8'h02, SRA 8'h03, SLT 8'h2A, SLTU 8'h2B, ADD 8'h20, ADDU 8'h21, SUB 8'h22, SUBU 8'h23, DIV 8'h1A, DIVU 8'h1B, NOP 8'h00;
  - alusel codes, FSM state encoding, ZeroWord.
- One sub-module, div_unit, contains the FSM, datapath and signed fixup. ex_stage instantiates it and keeps the combinational ALU and stall/whilo muxing.

Test Plan:
- OR: reg1=F0F0_0000, reg2=0000_0F0F, wd=3, wreg=1 -> same cycle wdata_o=F0F0_0F0F, wreg_o=1, wd_o=3.
- SRA: reg1=4, reg2=8000_0010 -> wdata_o=F800_0001. SLTU with reg1=1, reg2=FFFF_FFFF -> wdata_o=1.
- ADD overflow: 7FFF_FFFF+1 -> wdata_o=8000_0000, wreg_o=0. ADDU on the same operands -> wreg_o=1.
- DIVU: reg1=100, reg2=7 -> stallreq_o high in cycles 0..32; cycle 33 whilo_o=1, lo_o=14, hi_o=2; cycle 34 IDLE.
- DIV: reg1=FFFF_FFF9 (-7), reg2=2 -> lo_o=FFFF_FFFD, hi_o=FFFF_FFFF. DIVU by 0 -> cycle 2 whilo_o=1, hi_o=lo_o=0.
- annul_i=1 in cycle 10 of a divide -> stallreq_o=0 that cycle, no whilo_o pulse. A rst=1 pulse mid-divide -> all outputs 0, FSM in IDLE.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// Shared widths, opcode/select codes and divider state encoding
// for the execute stage and its divider.
package ex_stage_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;
  localparam int AluOpBus   = 8;
  localparam int AluSelBus  = 3;

  localparam logic [7:0] EXE_AND_OP  = 8'h24;
  localparam logic [7:0] EXE_OR_OP   = 8'h25;
  localparam logic [7:0] EXE_XOR_OP  = 8'h26;
  localparam logic [7:0] EXE_NOR_OP  = 8'h27;
  localparam logic [7:0] EXE_SLL_OP  = 8'h7C;
  localparam logic [7:0] EXE_SRL_OP  = 8'h02;
  localparam logic [7:0] EXE_SRA_OP  = 8'h03;
  localparam logic [7:0] EXE_SLT_OP  = 8'h2A;
  localparam logic [7:0] EXE_SLTU_OP = 8'h2B;
  localparam logic [7:0] EXE_ADD_OP  = 8'h20;
  localparam logic [7:0] EXE_ADDU_OP = 8'h21;
  localparam logic [7:0] EXE_SUB_OP  = 8'h22;
  localparam logic [7:0] EXE_SUBU_OP = 8'h23;
  localparam logic [7:0] EXE_DIV_OP  = 8'h1A;
  localparam logic [7:0] EXE_DIVU_OP = 8'h1B;
  localparam logic [7:0] EXE_NOP_OP  = 8'h00;

  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [2:0] EXE_RES_ARITH = 3'b100;

  localparam logic [1:0] DIV_IDLE  = 2'd0;
  localparam logic [1:0] DIV_DZERO = 2'd1;
  localparam logic [1:0] DIV_ON    = 2'd2;
  localparam logic [1:0] DIV_END   = 2'd3;

  localparam logic [RegBus-1:0] ZeroWord = '0;

endpackage

// File: rtl/ex_stage_div_unit.sv
// Radix-2 restoring divider: FSM, 65-bit shift-subtract datapath, sign fixup.
// Ports: clk/rst, start/sgn/annul, op1/op2 in; state, hi (rem), lo (quot) out.
module div_unit
  import ex_stage_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sgn,
  input  logic         annul,
  input  logic [W-1:0] op1,
  input  logic [W-1:0] op2,
  output logic [1:0]   state,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam int CW = $clog2(W) + 1;

  logic [1:0]    st;
  logic [2*W:0]  acc;
  logic [W-1:0]  dvs;
  logic [CW-1:0] cnt;
  logic          neg_q;
  logic          neg_r;

  logic [W-1:0]  abs1;
  logic [W-1:0]  abs2;
  logic [W+1:0]  diff;
  logic [2*W:0]  step;
  logic [W-1:0]  q;
  logic [W-1:0]  r;

  always_comb begin
    abs1 = (sgn && op1[W-1]) ? (~op1 + W'(1)) : op1;
    abs2 = (sgn && op2[W-1]) ? (~op2 + W'(1)) : op2;
    // acc[2W:W-1] is the partial remainder after the left shift
    diff = acc[2*W:W-1] - {2'b00, dvs};
    if (diff[W+1]) begin
      step = {acc[2*W-1:0], 1'b0};
    end else begin
      step = {diff[W:0], acc[W-2:0], 1'b1};
    end
    q  = acc[W-1:0];
    r  = acc[2*W-1:W];
    lo = neg_q ? (~q + W'(1)) : q;
    hi = neg_r ? (~r + W'(1)) : r;
  end

  always_ff @(posedge clk) begin
    if (rst || annul) begin
      st <= DIV_IDLE;
    end else begin
      unique case (st)
        DIV_IDLE: begin
          if (start) begin
            if (op2 == '0) begin
              st <= DIV_DZERO;
            end else begin
              st    <= DIV_ON;
              acc   <= {{(W+1){1'b0}}, abs1};
              dvs   <= abs2;
              cnt   <= '0;
              neg_q <= sgn && (op1[W-1] ^ op2[W-1]);
              neg_r <= sgn && op1[W-1];
            end
          end
        end
        DIV_DZERO: begin
          acc   <= '0;
          neg_q <= 1'b0;
          neg_r <= 1'b0;
          st    <= DIV_END;
        end
        DIV_ON: begin
          acc <= step;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(W - 1)) begin
            st <= DIV_END;
          end
        end
        DIV_END: begin
          st <= DIV_IDLE;
        end
        default: begin
          st <= DIV_IDLE;
        end
      endcase
    end
  end

  assign state = st;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle logic/shift/arith ALU plus multi-cycle divider.
// Ports: ID/EX operands in; write-back triple, HI/LO write port, stall out.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DATA_W   = RegBus,
  parameter int ADDR_W   = RegAddrBus,
  parameter int ALUOP_W  = AluOpBus,
  parameter int ALUSEL_W = AluSelBus
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ALUOP_W-1:0]  aluop_i,
  input  logic [ALUSEL_W-1:0] alusel_i,
  input  logic [DATA_W-1:0]   reg1_i,
  input  logic [DATA_W-1:0]   reg2_i,
  input  logic [ADDR_W-1:0]   wd_i,
  input  logic                wreg_i,
  input  logic                annul_i,
  output logic [ADDR_W-1:0]   wd_o,
  output logic                wreg_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic                whilo_o,
  output logic [DATA_W-1:0]   hi_o,
  output logic [DATA_W-1:0]   lo_o,
  output logic                stallreq_o
);

  localparam int SH_W = $clog2(DATA_W);

  logic [DATA_W-1:0] logic_res;
  logic [DATA_W-1:0] shift_res;
  logic [DATA_W-1:0] arith_res;
  logic [DATA_W-1:0] b_eff;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] result;
  logic [SH_W-1:0]   sa;
  logic              is_sub;
  logic              ov;
  logic              is_div;
  logic              div_sgn;
  logic [1:0]        div_st;
  logic [DATA_W-1:0] div_hi;
  logic [DATA_W-1:0] div_lo;

  assign sa     = reg1_i[SH_W-1:0];
  assign is_sub = (aluop_i == EXE_SUB_OP) || (aluop_i == EXE_SUBU_OP);
  assign b_eff  = is_sub ? (~reg2_i + DATA_W'(1)) : reg2_i;
  assign sum    = reg1_i + b_eff;
  // signed overflow: same-sign addends, result sign flipped
  assign ov = ((aluop_i == EXE_ADD_OP) || (aluop_i == EXE_SUB_OP))
           && (reg1_i[DATA_W-1] == b_eff[DATA_W-1])
           && (sum[DATA_W-1] != reg1_i[DATA_W-1]);

  always_comb begin
    logic_res = '0;
    case (aluop_i)
      EXE_AND_OP: logic_res = reg1_i & reg2_i;
      EXE_OR_OP:  logic_res = reg1_i | reg2_i;
      EXE_XOR_OP: logic_res = reg1_i ^ reg2_i;
      EXE_NOR_OP: logic_res = ~(reg1_i | reg2_i);
      default:    logic_res = '0;
    endcase
  end

  always_comb begin
    shift_res = '0;
    case (aluop_i)
      EXE_SLL_OP: shift_res = reg2_i << sa;
      EXE_SRL_OP: shift_res = reg2_i >> sa;
      EXE_SRA_OP: shift_res = $signed(reg2_i) >>> sa;
      default:    shift_res = '0;
    endcase
  end

  always_comb begin
    arith_res = '0;
    case (aluop_i)
      EXE_ADD_OP, EXE_ADDU_OP,
      EXE_SUB_OP, EXE_SUBU_OP:
        arith_res = sum;
      EXE_SLT_OP:
        arith_res = {{(DATA_W-1){1'b0}},
                     $signed(reg1_i) < $signed(reg2_i)};
      EXE_SLTU_OP:
        arith_res = {{(DATA_W-1){1'b0}}, reg1_i < reg2_i};
      default:
        arith_res = '0;
    endcase
  end

  always_comb begin
    result = '0;
    unique case (alusel_i)
      EXE_RES_LOGIC: result = logic_res;
      EXE_RES_SHIFT: result = shift_res;
      EXE_RES_ARITH: result = arith_res;
      default:       result = '0;
    endcase
  end

  assign is_div  = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
  assign div_sgn = (aluop_i == EXE_DIV_OP);

  div_unit #(
    .W(DATA_W)
  ) u_div (
    .clk  (clk),
    .rst  (rst),
    .start(is_div && !annul_i),
    .sgn  (div_sgn),
    .annul(annul_i),
    .op1  (reg1_i),
    .op2  (reg2_i),
    .state(div_st),
    .hi   (div_hi),
    .lo   (div_lo)
  );

  assign wd_o    = rst ? '0 : wd_i;
  assign wreg_o  = !rst && wreg_i && !ov;
  assign wdata_o = rst ? '0 : result;

  assign stallreq_o = !rst && !annul_i
                   && (((div_st == DIV_IDLE) && is_div)
                    || (div_st == DIV_DZERO)
                    || (div_st == DIV_ON));

  assign whilo_o = !rst && !annul_i && (div_st == DIV_END);
  assign hi_o    = whilo_o ? div_hi : '0;
  assign lo_o    = whilo_o ? div_lo : '0;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: random ALU ops and divides
// against a plain-arithmetic reference model.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  aluop = 8'h00;
  logic [2:0]  alusel = 3'b000;
  logic [31:0] reg1 = '0;
  logic [31:0] reg2 = '0;
  logic [4:0]  wd = '0;
  logic        wreg = 1'b0;
  logic        annul = 1'b0;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        whilo_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        stallreq_o;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk       (clk),
    .rst       (rst),
    .aluop_i   (aluop),
    .alusel_i  (alusel),
    .reg1_i    (reg1),
    .reg2_i    (reg2),
    .wd_i      (wd),
    .wreg_i    (wreg),
    .annul_i   (annul),
    .wd_o      (wd_o),
    .wreg_o    (wreg_o),
    .wdata_o   (wdata_o),
    .whilo_o   (whilo_o),
    .hi_o      (hi_o),
    .lo_o      (lo_o),
    .stallreq_o(stallreq_o)
  );

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
  } aexp_t;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } dexp_t;

  aexp_t aq[$];
  dexp_t dq[$];

  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  logic vld = 1'b0;
  logic chk_stall = 1'b0;
  logic exp_stall = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic aexp_t alu_model(
    input logic [7:0] op, input logic [2:0] sel,
    input logic [31:0] a, input logic [31:0] b,
    input logic [4:0] d, input logic w);
    aexp_t e;
    logic [31:0] res;
    logic [31:0] nb;
    logic ovf;
    res = 32'h0;
    ovf = 1'b0;
    nb  = 32'h0 - b;
    if (sel == 3'b001) begin
      case (op)
        EXE_AND_OP: res = a & b;
        EXE_OR_OP:  res = a | b;
        EXE_XOR_OP: res = a ^ b;
        EXE_NOR_OP: res = ~(a | b);
        default:    res = 32'h0;
      endcase
    end else if (sel == 3'b010) begin
      case (op)
        EXE_SLL_OP: res = b << a[4:0];
        EXE_SRL_OP: res = b >> a[4:0];
        EXE_SRA_OP: res = $signed(b) >>> a[4:0];
        default:    res = 32'h0;
      endcase
    end else if (sel == 3'b100) begin
      case (op)
        EXE_ADD_OP: begin
          res = a + b;
          ovf = (a[31] == b[31]) && (res[31] != a[31]);
        end
        EXE_ADDU_OP: res = a + b;
        EXE_SUB_OP: begin
          res = a - b;
          ovf = (a[31] == nb[31]) && (res[31] != a[31]);
        end
        EXE_SUBU_OP: res = a - b;
        EXE_SLT_OP:  res = ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
        EXE_SLTU_OP: res = (a < b) ? 32'h1 : 32'h0;
        default:     res = 32'h0;
      endcase
    end
    e.wd    = d;
    e.wreg  = w && !ovf;
    e.wdata = res;
    return e;
  endfunction

  // signed quotient truncates toward zero; remainder follows dividend
  function automatic logic [63:0] div_model(
    input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0] qq;
    logic [31:0] rr;
    sa = a;
    sb = b;
    if (b == 32'h0) begin
      qq = 32'h0;
      rr = 32'h0;
    end else if (sgn) begin
      qq = sa / sb;
      rr = sa % sb;
    end else begin
      qq = a / b;
      rr = a % b;
    end
    return {rr, qq};
  endfunction

  always @(negedge clk) begin
    aexp_t e;
    dexp_t d;
    if (rst === 1'b1) begin
      check("rst_wb", {wd_o, wreg_o, wdata_o, whilo_o, stallreq_o}, '0);
      check("rst_hilo", {hi_o, lo_o}, '0);
    end else begin
      if (vld) begin
        if (aq.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL alu_queue: got empty expected entry");
        end else begin
          e = aq.pop_front();
          check("alu_wdata", wdata_o, e.wdata);
          check("alu_wd_wreg", {wd_o, wreg_o}, {e.wd, e.wreg});
        end
      end
      if (chk_stall) check("stallreq", stallreq_o, exp_stall);
      if (dq.size() > 0 && dq[0].cyc < cyc) begin
        n_vec++;
        n_bad++;
        $display("FAIL div_missing: got no whilo expected at cycle %0d",
                 dq[0].cyc);
        void'(dq.pop_front());
      end
      if (whilo_o === 1'b1) begin
        if (dq.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL div_spurious: got whilo at cycle %0d expected none",
                   cyc);
        end else begin
          d = dq.pop_front();
          check("div_cycle", 64'(cyc), 64'(d.cyc));
          check("div_hi", hi_o, d.hi);
          check("div_lo", lo_o, d.lo);
        end
      end else if (chk_stall) begin
        check("hilo_idle", {whilo_o, hi_o, lo_o}, '0);
      end
    end
  end

  task automatic alu(input logic [7:0] op, input logic [2:0] sel,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] d, input logic w);
    @(posedge clk);
    #1;
    rst = 1'b0;
    annul = 1'b0;
    aluop = op;
    alusel = sel;
    reg1 = a;
    reg2 = b;
    wd = d;
    wreg = w;
    aq.push_back(alu_model(op, sel, a, b, d, w));
    vld = 1'b1;
    chk_stall = 1'b1;
    exp_stall = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      rst = 1'b0;
      annul = 1'b0;
      vld = 1'b0;
      aluop = EXE_NOP_OP;
      alusel = EXE_RES_NOP;
      wreg = 1'b0;
      chk_stall = 1'b1;
      exp_stall = 1'b0;
    end
  endtask

  task automatic divide(input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input int annul_at,
                        input int rst_at);
    int lat;
    logic [63:0] m;
    dexp_t d;
    lat = (b == 32'h0) ? 2 : 33;
    m = div_model(sgn, a, b);
    @(posedge clk);
    #1;
    vld = 1'b0;
    rst = 1'b0;
    annul = 1'b0;
    aluop = sgn ? EXE_DIV_OP : EXE_DIVU_OP;
    alusel = EXE_RES_NOP;
    reg1 = a;
    reg2 = b;
    wd = 5'($urandom);
    wreg = 1'b0;
    chk_stall = 1'b1;
    if (annul_at < 0 && rst_at < 0) begin
      d.hi = m[63:32];
      d.lo = m[31:0];
      d.cyc = cyc + lat;
      dq.push_back(d);
    end
    for (int i = 0; i <= lat; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      if (i == annul_at) begin
        annul = 1'b1;
        exp_stall = 1'b0;
        break;
      end
      if (i == rst_at) begin
        rst = 1'b1;
        break;
      end
      exp_stall = (i < lat);
    end
    idle(3);
  endtask

  localparam int NOPS = 13;
  logic [7:0] ops [NOPS] = '{
    EXE_AND_OP, EXE_OR_OP, EXE_XOR_OP, EXE_NOR_OP,
    EXE_SLL_OP, EXE_SRL_OP, EXE_SRA_OP,
    EXE_SLT_OP, EXE_SLTU_OP, EXE_ADD_OP, EXE_ADDU_OP,
    EXE_SUB_OP, EXE_SUBU_OP};
  logic [2:0] sels [NOPS] = '{
    3'b001, 3'b001, 3'b001, 3'b001,
    3'b010, 3'b010, 3'b010,
    3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};

  initial begin
    int j;
    logic [31:0] a;
    logic [31:0] b;
    logic s;
    rst = 1'b1;
    aluop = EXE_OR_OP;
    alusel = EXE_RES_LOGIC;
    reg1 = 32'hF0F0_0000;
    reg2 = 32'h0000_0F0F;
    wd = 5'd3;
    wreg = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    aluop = EXE_DIVU_OP;
    repeat (2) @(posedge clk);

    alu(EXE_OR_OP,   3'b001, 32'hF0F0_0000, 32'h0000_0F0F, 5'd3, 1'b1);
    alu(EXE_SRA_OP,  3'b010, 32'd4, 32'h8000_0010, 5'd4, 1'b1);
    alu(EXE_SLTU_OP, 3'b100, 32'd1, 32'hFFFF_FFFF, 5'd5, 1'b1);
    alu(EXE_SLT_OP,  3'b100, 32'd1, 32'hFFFF_FFFF, 5'd6, 1'b1);
    alu(EXE_ADD_OP,  3'b100, 32'h7FFF_FFFF, 32'd1, 5'd7, 1'b1);
    alu(EXE_ADDU_OP, 3'b100, 32'h7FFF_FFFF, 32'd1, 5'd8, 1'b1);
    alu(EXE_SUB_OP,  3'b100, 32'h8000_0000, 32'd1, 5'd9, 1'b1);
    alu(EXE_SUBU_OP, 3'b100, 32'h8000_0000, 32'd1, 5'd10, 1'b1);
    alu(EXE_SLL_OP,  3'b010, 32'd31, 32'h0000_0003, 5'd11, 1'b1);
    alu(EXE_SRL_OP,  3'b010, 32'd31, 32'h8000_0000, 5'd12, 1'b1);
    alu(EXE_NOR_OP,  3'b001, 32'h0F0F_0F0F, 32'h0000_FFFF, 5'd13, 1'b0);
    alu(EXE_NOP_OP,  3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 5'd14, 1'b1);
    alu(EXE_NOP_OP,  3'b000, 32'h1234_5678, 32'h9ABC_DEF0, 5'd15, 1'b1);

    for (int n = 0; n < 300; n++) begin
      j = $urandom_range(0, NOPS - 1);
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) a = {a[31], {31{~a[31]}}};
      alu(ops[j], sels[j], a, b, 5'($urandom), 1'($urandom));
    end
    idle(1);

    divide(1'b0, 32'd100, 32'd7, -1, -1);
    divide(1'b1, 32'hFFFF_FFF9, 32'd2, -1, -1);
    divide(1'b0, 32'd55, 32'd0, -1, -1);
    divide(1'b1, 32'h8000_0000, 32'd0, -1, -1);
    divide(1'b0, 32'd100, 32'd7, 10, -1);
    divide(1'b1, 32'd1000, 32'hFFFF_FFFD, -1, 10);
    divide(1'b1, 32'd1000, 32'hFFFF_FFFD, -1, -1);
    divide(1'b0, 32'hFFFF_FFFF, 32'd1, -1, -1);
    divide(1'b0, 32'd5, 32'hFFFF_FFFF, 0, -1);

    for (int n = 0; n < 12; n++) begin
      s = 1'($urandom);
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (b == 32'h0) b = 32'd3;
      if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd5;
      divide(s, a, b, -1, -1);
    end

    alu(EXE_XOR_OP, 3'b001, 32'hAAAA_5555, 32'hFFFF_0000, 5'd1, 1'b1);
    idle(3);
    if (dq.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL div_pending: got %0d outstanding expected 0",
               dq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
